// File: rtl/ternary_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ternary_pkg
// Purpose  : Shared trit encodings, packing limits and FSM state type for the
//            ternary trit unpacker.
// Revision : 1.0  initial release
// ============================================================================
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO       = 2'b00;
  localparam logic [1:0] TRIT_POS        = 2'b01;
  localparam logic [1:0] TRIT_NEG        = 2'b10;
  localparam int         TRITS_PER_BYTE  = 5;
  localparam logic [7:0] MAX_PACKED_BYTE = 8'd242;

  typedef logic [1:0] trit_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

  // Base-3 digit (0,1,2) to simple 2-bit trit code.
  function automatic trit_t digit_to_trit(input logic [1:0] digit);
    case (digit)
      2'd1:    return TRIT_POS;
      2'd2:    return TRIT_NEG;
      default: return TRIT_ZERO;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ternary_byte_decode.sv
`default_nettype none
// ============================================================================
// Module   : ternary_byte_decode
// Purpose  : Combinational split of one packed byte into five 2-bit trits;
//            bytes above 242 are flagged and decode to all-zero trits.
// Revision : 1.0  initial release
// ============================================================================
module ternary_byte_decode
  import ternary_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [9:0] trits,
  output logic       invalid
);

  logic [7:0] rem;
  logic [1:0] digit;

  always_comb begin
    rem     = in_byte;
    digit   = 2'd0;
    trits   = '0;
    invalid = (in_byte > MAX_PACKED_BYTE);
    for (int i = 0; i < TRITS_PER_BYTE; i++) begin
      digit             = 2'(rem % 8'd3);
      trits[2*i +: 2]   = digit_to_trit(digit);
      rem               = rem / 8'd3;
    end
    if (invalid) begin
      trits = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ternary_trit_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : ternary_trit_unpacker
// Purpose  : Drains base-3 packed words one byte per beat into 5-trit beats,
//            with invalid-byte flagging, packet-end tracking and error count.
//            Optional TRIT_UNPACK_ZMASK_EN adds m_zmask / m_allzero outputs.
// Revision : 1.0  initial release
// ============================================================================
module ternary_trit_unpacker
  import ternary_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int ERR_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*WORD_BYTES-1:0]       s_data,
  input  logic [$clog2(WORD_BYTES):0]   s_bytes,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [9:0]                    m_trits,
  output logic                          m_last,
  output logic                          m_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  input  logic                          err_clr,
  output logic [ERR_W-1:0]              err_count,
  output logic                          busy
`ifdef TRIT_UNPACK_ZMASK_EN
  ,
  output logic [4:0]                    m_zmask,
  output logic                          m_allzero
`endif
);

  localparam int                CNT_W  = $clog2(WORD_BYTES) + 1;
  localparam logic [CNT_W-1:0]  WB_CNT = CNT_W'(WORD_BYTES);

  unpack_state_e             state_q, state_d;
  logic [8*WORD_BYTES-1:0]   word_q, word_d;
  logic [CNT_W-1:0]          nbytes_q, nbytes_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic                      pkt_last_q, pkt_last_d;
  logic [9:0]                m_trits_q, m_trits_d;
  logic                      m_last_q, m_last_d;
  logic                      m_err_q, m_err_d;
  logic                      m_valid_q, m_valid_d;
  logic [ERR_W-1:0]          err_count_q, err_count_d;

  logic [CNT_W-1:0]          n_in;
  logic [CNT_W-1:0]          idx_nxt;
  logic                      final_beat;
  logic                      xfer;
  logic                      accept;
  logic                      load_beat;
  logic                      go_idle;
  logic                      s_ready_w;
  logic [7:0]                held_byte;
  logic [7:0]                dec_in;
  logic [9:0]                dec_trits;
  logic                      dec_invalid;

  ternary_byte_decode u_decode (
    .in_byte (dec_in),
    .trits   (dec_trits),
    .invalid (dec_invalid)
  );

  // Byte selection and handshake
  always_comb begin
    n_in       = (s_bytes == '0 || s_bytes > WB_CNT) ? WB_CNT : s_bytes;
    idx_nxt    = idx_q + CNT_W'(1);
    final_beat = (idx_q == nbytes_q - CNT_W'(1));
    xfer       = m_valid_q && m_ready;

    held_byte = 8'd0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx_nxt == CNT_W'(i)) begin
        held_byte = word_q[8*i +: 8];
      end
    end

    s_ready_w = 1'b0;
    case (state_q)
      ST_IDLE:  s_ready_w = !reset;
      ST_DRAIN: s_ready_w = !reset && final_beat && m_ready;
      default:  s_ready_w = 1'b0;
    endcase

    accept    = s_valid && s_ready_w;
    load_beat = accept || (state_q == ST_DRAIN && xfer && !final_beat);
    go_idle   = !accept && (state_q == ST_DRAIN) && xfer && final_beat;
    dec_in    = accept ? s_data[7:0] : held_byte;
  end

  // Next-state and output-register update
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    nbytes_d    = nbytes_q;
    idx_d       = idx_q;
    pkt_last_d  = pkt_last_q;
    m_trits_d   = m_trits_q;
    m_last_d    = m_last_q;
    m_err_d     = m_err_q;
    m_valid_d   = m_valid_q;
    err_count_d = err_count_q;

    if (accept) begin
      state_d    = ST_DRAIN;
      word_d     = s_data;
      nbytes_d   = n_in;
      idx_d      = '0;
      pkt_last_d = s_last;
      m_trits_d  = dec_trits;
      m_err_d    = dec_invalid;
      m_last_d   = s_last && (n_in == CNT_W'(1));
      m_valid_d  = 1'b1;
    end else if (load_beat) begin
      idx_d     = idx_nxt;
      m_trits_d = dec_trits;
      m_err_d   = dec_invalid;
      m_last_d  = pkt_last_q && (idx_nxt == nbytes_q - CNT_W'(1));
    end else if (go_idle) begin
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
      m_trits_d = '0;
      m_last_d  = 1'b0;
      m_err_d   = 1'b0;
    end

    // Clear has priority over a coincident increment.
    if (err_clr) begin
      err_count_d = '0;
    end else if (xfer && m_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      pkt_last_q  <= 1'b0;
      m_trits_q   <= '0;
      m_last_q    <= 1'b0;
      m_err_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      nbytes_q    <= nbytes_d;
      idx_q       <= idx_d;
      pkt_last_q  <= pkt_last_d;
      m_trits_q   <= m_trits_d;
      m_last_q    <= m_last_d;
      m_err_q     <= m_err_d;
      m_valid_q   <= m_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign s_ready   = s_ready_w;
  assign m_trits   = m_trits_q;
  assign m_last    = m_last_q;
  assign m_err     = m_err_q;
  assign m_valid   = m_valid_q;
  assign err_count = err_count_q;
  assign busy      = (state_q == ST_DRAIN);

`ifdef TRIT_UNPACK_ZMASK_EN
  logic [4:0] zmask_q, zmask_d, dec_zmask;
  logic       allzero_q, allzero_d;

  // Invalid bytes decode to all-zero trits, so the mask is all ones for them.
  always_comb begin
    for (int i = 0; i < TRITS_PER_BYTE; i++) begin
      dec_zmask[i] = (dec_trits[2*i +: 2] == TRIT_ZERO);
    end
    zmask_d   = zmask_q;
    allzero_d = allzero_q;
    if (load_beat) begin
      zmask_d   = dec_zmask;
      allzero_d = &dec_zmask;
    end else if (go_idle) begin
      zmask_d   = '0;
      allzero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zmask_q   <= '0;
      allzero_q <= 1'b0;
    end else begin
      zmask_q   <= zmask_d;
      allzero_q <= allzero_d;
    end
  end

  assign m_zmask   = zmask_q;
  assign m_allzero = allzero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ternary_trit_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_trit_unpacker
// Purpose  : Directed self-checking bench with a beat scoreboard for the
//            ternary trit unpacker.
// Revision : 1.0  initial release
// ============================================================================
module tb_ternary_trit_unpacker;

  localparam int WORD_BYTES = 4;
  localparam int ERR_W      = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [8*WORD_BYTES-1:0] s_data;
  logic [2:0]              s_bytes;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;
  logic [9:0]              m_trits;
  logic                    m_last;
  logic                    m_err;
  logic                    m_valid;
  logic                    m_ready;
  logic                    err_clr;
  logic [ERR_W-1:0]        err_count;
  logic                    busy;
`ifdef TRIT_UNPACK_ZMASK_EN
  logic [4:0]              m_zmask;
  logic                    m_allzero;
`endif

  int checks   = 0;
  int failures = 0;
  logic [11:0] sb[$];
  logic        gap_mon = 1'b0;
  int          gap_cnt = 0;
  int          sr_cnt  = 0;

  always #5 clk = ~clk;

  ternary_trit_unpacker #(
    .WORD_BYTES (WORD_BYTES),
    .ERR_W      (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_bytes   (s_bytes),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_trits   (m_trits),
    .m_last    (m_last),
    .m_err     (m_err),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_clr   (err_clr),
    .err_count (err_count),
    .busy      (busy)
`ifdef TRIT_UNPACK_ZMASK_EN
    ,
    .m_zmask   (m_zmask),
    .m_allzero (m_allzero)
`endif
  );

  // Reference decode: digit i = (b / 3^i) % 3 via an explicit power of three.
  function automatic logic [9:0] ref_dec(input logic [7:0] b);
    logic [9:0] t;
    int pw, d;
    t  = '0;
    pw = 1;
    if (b > 8'd242) return 10'd0;
    for (int i = 0; i < 5; i++) begin
      d = (int'(b) / pw) % 3;
      t[2*i +: 2] = (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
      pw = pw * 3;
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat monitor: every transferred beat must match the scoreboard head.
  always @(negedge clk) begin
    logic [11:0] exp;
    if (!reset && m_valid && m_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL beat_unexpected observed=%0h expected=none", {m_trits, m_last, m_err});
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        assert ({m_trits, m_last, m_err} === exp) else begin
          failures++;
          $error("FAIL beat observed=%0h expected=%0h", {m_trits, m_last, m_err}, exp);
        end
`ifdef TRIT_UNPACK_ZMASK_EN
        begin
          logic [4:0] zm;
          for (int i = 0; i < 5; i++) zm[i] = (exp[2*i+2 +: 2] == 2'b00);
          checks++;
          assert ({m_zmask, m_allzero} === {zm, &zm}) else begin
            failures++;
            $error("FAIL zmask observed=%0h expected=%0h", {m_zmask, m_allzero}, {zm, &zm});
          end
        end
`endif
      end
    end
    if (gap_mon && !m_valid) gap_cnt++;
    if (gap_mon && s_ready)  sr_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 just after the word is taken.
  task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
    int n, waitc;
    logic [7:0] b;
    s_data  = data;
    s_bytes = nb;
    s_last  = last;
    s_valid = 1'b1;
    waitc   = 0;
    while (waitc < 300) begin
      @(negedge clk);
      if (s_ready) break;
      waitc++;
    end
    checks++;
    assert (waitc < 300) else begin
      failures++;
      $error("FAIL s_ready_timeout observed=%0d expected=<300", waitc);
    end
    @(posedge clk);
    if (waitc < 300) begin
      n = (nb == 0 || nb > 3'd4) ? 4 : int'(nb);
      for (int k = 0; k < n; k++) begin
        b = data[8*k +: 8];
        sb.push_back({ref_dec(b), last && (k == n - 1), b > 8'd242});
      end
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 300) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=<300", n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] held;
    reset   = 1'b1;
    s_data  = '0;
    s_bytes = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_m_valid",   32'(m_valid),   32'd0);
    check("rst_m_trits",   32'(m_trits),   32'd0);
    check("rst_m_last",    32'(m_last),    32'd0);
    check("rst_m_err",     32'(m_err),     32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_s_ready",   32'(s_ready),   32'd1);
    @(posedge clk); #1;

    // Full word, mixed digits including the 242 boundary
    send_word(32'h00F2_0501, 3'd4, 1'b1);
    wait_idle();

    // Short word: upper bytes ignored, then back to IDLE
    send_word(32'hFFFF_1234, 3'd2, 1'b1);
    wait_idle();
    @(negedge clk);
    check("short_idle_s_ready", 32'(s_ready), 32'd1);
    check("short_idle_busy",    32'(busy),    32'd0);
    @(posedge clk); #1;

    // s_bytes of 0 and of 5 both mean a full word
    send_word(32'h0A0B_0C0D, 3'd0, 1'b0);
    send_word(32'hE1E2_E3F0, 3'd5, 1'b1);
    wait_idle();

    // Backpressure mid-word
    send_word(32'h8040_2010, 3'd4, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    held = {m_trits, m_last, m_err};
    @(negedge clk);
    check("hold_beat",  32'({m_trits, m_last, m_err}), 32'(held));
    check("hold_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle();

    // Back-to-back words at full rate
    gap_cnt = 0;
    sr_cnt  = 0;
    send_word(32'h0102_0304, 3'd4, 1'b0);
    gap_mon = 1'b1;
    send_word(32'h1121_3141, 3'd4, 1'b0);
    send_word(32'h5060_7080, 3'd4, 1'b1);
    gap_mon = 1'b0;
    wait_idle();
    check("b2b_gap",     32'(gap_cnt), 32'd0);
    check("b2b_s_ready", 32'(sr_cnt),  32'd2);

    // Invalid byte and clear-beats-increment
    send_word(32'h0000_00FF, 3'd1, 1'b1);
    wait_idle();
    check("err_count_one", 32'(err_count), 32'd1);
    m_ready = 1'b0;
    send_word(32'h0000_00FF, 3'd1, 1'b1);
    @(negedge clk);
    check("err_beat_flag",  32'(m_err),   32'd1);
    check("err_beat_trits", 32'(m_trits), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_wins", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Saturation: 20 invalid bytes into a 4-bit counter
    repeat (5) send_word(32'hFFFF_FFFF, 3'd4, 1'b1);
    wait_idle();
    check("err_saturate", 32'(err_count), 32'd15);

    // Reset during beat 2
    send_word(32'hF3E4_0204, 3'd4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_m_valid",   32'(m_valid),   32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_m_last",    32'(m_last),    32'd0);
    check("mid_rst_s_ready",   32'(s_ready),   32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_word(32'h0000_0007, 3'd1, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
